// File: rtl/sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package sub_pkg;

    // Operation sequencing: load operands, ripple digits, hold result.
    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

    localparam int SUB_WIDTH = 16;
    localparam int SUB_DIGIT = 4;
    localparam int NDIGITS   = SUB_WIDTH / SUB_DIGIT;

    // Counter width that stays at least one bit for a single-digit build.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_width(NDIGITS);

endpackage

// File: rtl/digit_sub4.sv
// Combinational 4-bit carry-lookahead slice; subtraction is obtained by
// feeding the inverted subtrahend and a carry-in of 1 on the first digit.
module digit_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] bn,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       pg,
    output logic       gg
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ bn;
    assign g = a & bn;

    // Internal carries expanded in lookahead form rather than rippled.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;

    // Group propagate/generate let a higher lookahead level skip this slice.
    assign pg   = &p;
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign cout = gg | (pg & cin);

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Digit-serial two's-complement subtractor: D = A - B, one DIGIT-wide slice
// per clock, least-significant digit first, valid/ready on both sides.
// Optional build macro SUB_SATURATE_EN: on signed overflow the result is
// replaced by the signed saturated value instead of the wrapped difference.
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int DIGIT = SUB_DIGIT
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int                N_DIG = WIDTH / DIGIT;
    localparam int                CW    = cnt_width(N_DIG);
    localparam logic [CW-1:0]     LAST  = CW'(N_DIG - 1);
    localparam int                MSB   = WIDTH - 1;
    localparam logic [WIDTH-1:0]  SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]  SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    sub_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bn_q, bn_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_bn;
    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic             dig_pg;
    logic             dig_gg;
    logic             unused_group_terms;

    // The single slice is time-multiplexed over the digits by the counter.
    assign dig_a  = a_q[cnt_q*DIGIT +: DIGIT];
    assign dig_bn = bn_q[cnt_q*DIGIT +: DIGIT];

    digit_sub4 u_digit (
        .a    (dig_a),
        .bn   (dig_bn),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_cout),
        .pg   (dig_pg),
        .gg   (dig_gg)
    );

    // Group terms matter only when slices are chained combinationally.
    assign unused_group_terms = dig_pg ^ dig_gg;

    // Next-state logic: operand load, digit step, result hand-off.
    always_comb begin
        // NOTE: every _d starts from its current value so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        bn_d        = bn_q;
        d_d         = d_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = A;
                    bn_d       = ~B;
                    cnt_d      = '0;
                    carry_d    = 1'b1;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                d_d[cnt_q*DIGIT +: DIGIT] = dig_s;
                carry_d = dig_cout;
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    borrow_d    = ~dig_cout;
                    // Operand signs differ exactly when A[MSB] equals ~B[MSB].
                    ovf_d       = (a_q[MSB] == bn_q[MSB]) &&
                                  (dig_s[DIGIT-1] != a_q[MSB]);
`ifdef SUB_SATURATE_EN
                    if (ovf_d) begin
                        d_d = a_q[MSB] ? SAT_NEG : SAT_POS;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous return to reset values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b1;
            a_q         <= '0;
            bn_q        <= '0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop update from pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            bn_q        <= bn_d;
            d_q         <= d_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign D          = d_q;
    assign borrow_out = borrow_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor: expected results are pushed
// at operand acceptance and compared when the result handshake completes.
// Honours SUB_SATURATE_EN the same way as the design.
module tb_nibble_serial_subtractor;
    import sub_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] d;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic         Clk;
    logic         Reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         borrow_out;
    logic         ovf;

    nibble_serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .D          (D),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           results_seen = 0;
    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [W-1:0] last_d;
    logic         last_borrow;
    logic         last_ovf;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent reference: 17-bit unsigned difference plus sign rules.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        r;
        logic [W:0]  full;
        full     = {1'b0, a} - {1'b0, b};
        r.d      = full[W-1:0];
        r.borrow = full[W];
        r.ovf    = (a[W-1] != b[W-1]) && (r.d[W-1] != a[W-1]);
`ifdef SUB_SATURATE_EN
        if (r.ovf) r.d = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return r;
    endfunction

    // Result monitor: compare on every completed output handshake.
    always @(negedge Clk) begin
        if (Reset_n && out_valid && out_ready) begin
            results_seen++;
            if (sb_q.size() == 0) begin
                check("sb_nonempty_at_result", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check("D", D, mon_e.d);
                check("borrow_out", borrow_out, mon_e.borrow);
                check("ovf", ovf, mon_e.ovf);
                last_d      = D;
                last_borrow = borrow_out;
                last_ovf    = ovf;
            end
        end
    end

    // Present operands until accepted; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int acc_cyc);
        int waited = 0;
        bit ok = 1'b0;
        A = a;
        B = b;
        in_valid = 1'b1;
        while (!ok && waited < 100) begin
            @(negedge Clk);
            if (in_ready) ok = 1'b1;
            else waited++;
        end
        check("accepted", ok, 1);
        @(posedge Clk);
        acc_cyc = cyc;
        if (ok) sb_q.push_back(model(a, b));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 64) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("out_valid_seen", out_valid, 1);
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 64) begin
            @(posedge Clk);
            #1;
            k++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        send(a, b, t);
        drain();
    endtask

    initial begin
        int t0, t1, t2, n, seen_before;

        Reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_D", D, 0);
        check("rst_borrow", borrow_out, 0);
        check("rst_ovf", ovf, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Basic operation and latency.
        send(16'h1234, 16'h0234, t0);
        wait_valid(n);
        check("latency", n, NDIGITS);
        drain();
        check("t1_D", last_d, 16'h1000);
        check("t1_borrow", last_borrow, 0);
        check("t1_ovf", last_ovf, 0);

        run_op(16'h0000, 16'h0001);
        check("t2_D", last_d, 16'hFFFF);
        check("t2_borrow", last_borrow, 1);
        run_op(16'h0005, 16'h0005);
        check("t3_D", last_d, 16'h0000);
        check("t3_borrow", last_borrow, 0);

        run_op(16'h8000, 16'h0001);
        check("t4_ovf", last_ovf, 1);
        check("t4_borrow", last_borrow, 0);
`ifdef SUB_SATURATE_EN
        check("t4_D", last_d, 16'h8000);
`else
        check("t4_D", last_d, 16'h7FFF);
`endif
        run_op(16'h7FFF, 16'hFFFF);
        check("t5_ovf", last_ovf, 1);
`ifdef SUB_SATURATE_EN
        check("t5_D", last_d, 16'h7FFF);
`else
        check("t5_D", last_d, 16'h8000);
`endif

        // Backpressure: result held, new operands refused.
        out_ready = 1'b0;
        send(16'h4321, 16'h1111, t0);
        wait_valid(n);
        check("bp_latency", n, NDIGITS);
        A = 16'hDEAD;
        B = 16'hBEEF;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (sb_q.size() != 0) begin
                check("bp_D_stable", D, sb_q[0].d);
                check("bp_borrow_stable", borrow_out, sb_q[0].borrow);
                check("bp_ovf_stable", ovf, sb_q[0].ovf);
            end
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid_high", out_valid, 1);
        end
        @(posedge Clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        check("bp_out_valid_fell", out_valid, 0);
        check("bp_in_ready_back", in_ready, 1);
        check("bp_retired", sb_q.size(), 0);
        seen_before = results_seen;
        repeat (8) @(posedge Clk);
        #1;
        check("bp_no_extra_result", results_seen, seen_before);

        // Reset during the second RUN cycle discards the operation.
        send(16'h1234, 16'h1111, t0);
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_D", D, 0);
        check("mid_rst_in_ready", in_ready, 1);
        sb_q.delete();
        seen_before = results_seen;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (8) @(posedge Clk);
        #1;
        check("mid_rst_no_result", results_seen, seen_before);
        run_op(16'hFFFF, 16'h0001);
        check("post_rst_D", last_d, 16'hFFFE);

        // Back-to-back with both handshakes held high.
        send(16'h1111, 16'h0001, t0);
        send(16'hA000, 16'h5000, t1);
        send(16'h0000, 16'h8000, t2);
        check("b2b_gap1", t1 - t0, 6);
        check("b2b_gap2", t2 - t1, 6);
        drain();
        check("b2b_last_ovf", last_ovf, 1);
        check("b2b_last_borrow", last_borrow, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
